tpu_core: RTL and testbench

- 4x4 output-stationary systolic matrix-multiply engine; computes C = A x B.
- A is m x k, B is k x n, with m and n no greater than 4 and k up to 15.
- Reads A and B from the two operand global buffers and writes C into the output global buffer.
- Instantiated inside the TPU top level, between the start/done control and the three global buffers.

---
 rtl/tpu_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_tpu_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_core.sv
// 4x4 output-stationary systolic matrix-multiply engine: C = A x B with A m x k, B k x n.
// Operands stream from two synchronous-read buffers; saturated rows of C go to the output buffer.
module tpu_core #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        m,
  input  logic [3:0]        k,
  input  logic [3:0]        n,
  output logic              done,
  output logic [ADDR_W-1:0] index_a,
  input  logic [WORD_W-1:0] data_out_a,
  output logic [ADDR_W-1:0] index_b,
  input  logic [WORD_W-1:0] data_out_b,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] index_out,
  output logic [WORD_W-1:0] data_in_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [2:0]  m_reg;
  logic [2:0]  n_reg;
  logic [3:0]  k_reg;
  logic        rd_vld_reg;
  logic        dat_vld_reg;
  logic        clr;
  logic [2:0]  m_clamp;
  logic [2:0]  n_clamp;

  logic signed [7:0]       a_row  [4];
  logic signed [7:0]       b_col  [4];
  logic signed [7:0]       a_link [4][4];
  logic signed [7:0]       b_link [4][4];
  logic signed [ACC_W-1:0] acc    [4][4];
  logic [1:0]              row_sel;
  logic [WORD_W-1:0]       row_word;

  assign m_clamp = (m > 4'd4) ? 3'd4 : m[2:0];
  assign n_clamp = (n > 4'd4) ? 3'd4 : n[2:0];
  // A start that coincides with the completion pulse is dropped.
  assign clr     = (state_reg == S_IDLE) && start && !done;
  assign row_sel = cnt_reg[1:0];

  // Operand masking and input skew: lane gi is delayed gi cycles before entering the array.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [7:0] a_raw;
      logic signed [7:0] b_raw;

      assign a_raw = (dat_vld_reg && (3'(gi) < m_reg)) ? data_out_a[8*gi +: 8] : 8'h00;
      assign b_raw = (dat_vld_reg && (3'(gi) < n_reg)) ? data_out_b[8*gi +: 8] : 8'h00;

      if (gi == 0) begin : g_noskew
        assign a_row[gi] = a_raw;
        assign b_col[gi] = b_raw;
      end else begin : g_skew
        logic signed [7:0] a_sr_reg [gi];
        logic signed [7:0] b_sr_reg [gi];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < gi; i++) begin
              a_sr_reg[i] <= '0;
              b_sr_reg[i] <= '0;
            end
          end else if (clr) begin
            for (int i = 0; i < gi; i++) begin
              a_sr_reg[i] <= '0;
              b_sr_reg[i] <= '0;
            end
          end else begin
            a_sr_reg[0] <= a_raw;
            b_sr_reg[0] <= b_raw;
            for (int i = 1; i < gi; i++) begin
              a_sr_reg[i] <= a_sr_reg[i-1];
              b_sr_reg[i] <= b_sr_reg[i-1];
            end
          end
        end

        assign a_row[gi] = a_sr_reg[gi-1];
        assign b_col[gi] = b_sr_reg[gi-1];
      end

      assign a_link[gi][0] = a_row[gi];
      assign b_link[0][gi] = b_col[gi];
    end
  endgenerate

  // PE grid: a moves right, b moves down, one register per hop; the accumulator stays put.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_pe
        logic signed [ACC_W-1:0] acc_reg;
        logic signed [15:0]      prod;

        assign prod = a_link[gi][gj] * b_link[gi][gj];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            acc_reg <= '0;
          end else if (clr) begin
            acc_reg <= '0;
          end else begin
            acc_reg <= acc_reg + ACC_W'(prod);
          end
        end

        assign acc[gi][gj] = acc_reg;

        if (gj < 3) begin : g_fwd_a
          logic signed [7:0] a_fwd_reg;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              a_fwd_reg <= '0;
            end else if (clr) begin
              a_fwd_reg <= '0;
            end else begin
              a_fwd_reg <= a_link[gi][gj];
            end
          end
          assign a_link[gi][gj+1] = a_fwd_reg;
        end

        if (gi < 3) begin : g_fwd_b
          logic signed [7:0] b_fwd_reg;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              b_fwd_reg <= '0;
            end else if (clr) begin
              b_fwd_reg <= '0;
            end else begin
              b_fwd_reg <= b_link[gi][gj];
            end
          end
          assign b_link[gi+1][gj] = b_fwd_reg;
        end
      end
    end
  endgenerate

  // Row of C selected by the write counter, saturated to int8, lanes at or beyond n zeroed.
  generate
    for (gj = 0; gj < 4; gj++) begin : g_sat
      logic signed [ACC_W-1:0] v;
      logic [7:0]              sat;

      assign v = acc[row_sel][gj];

      always_comb begin
        sat = v[7:0];
        if (v > ACC_W'(127)) begin
          sat = 8'h7F;
        end else if (v < -ACC_W'(128)) begin
          sat = 8'h80;
        end
      end

      assign row_word[8*gj +: 8] = (3'(gj) < n_reg) ? sat : 8'h00;
    end
  endgenerate

  // Control FSM; every output is registered from the state of the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      m_reg       <= '0;
      n_reg       <= '0;
      k_reg       <= '0;
      rd_vld_reg  <= 1'b0;
      dat_vld_reg <= 1'b0;
      done        <= 1'b0;
      index_a     <= '0;
      index_b     <= '0;
      wr_en_out   <= 1'b0;
      index_out   <= '0;
      data_in_o   <= '0;
    end else begin
      rd_vld_reg  <= (state_reg == S_READ);
      dat_vld_reg <= rd_vld_reg;
      index_a     <= (state_reg == S_READ) ? {{(ADDR_W-4){1'b0}}, cnt_reg} : '0;
      index_b     <= (state_reg == S_READ) ? {{(ADDR_W-4){1'b0}}, cnt_reg} : '0;
      wr_en_out   <= (state_reg == S_WRITE);
      index_out   <= (state_reg == S_WRITE) ? {{(ADDR_W-4){1'b0}}, cnt_reg} : '0;
      data_in_o   <= (state_reg == S_WRITE) ? row_word : '0;
      done        <= (state_reg == S_DONE);

      case (state_reg)
        S_IDLE: begin
          if (clr) begin
            m_reg     <= m_clamp;
            n_reg     <= n_clamp;
            k_reg     <= k;
            cnt_reg   <= '0;
            state_reg <= (k == 4'd0) ? S_FLUSH : S_READ;
          end
        end
        S_READ: begin
          if (cnt_reg == k_reg - 4'd1) begin
            cnt_reg   <= '0;
            state_reg <= S_FLUSH;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_FLUSH: begin
          // Read latency plus three row and three column skew stages.
          if (cnt_reg == 4'd6) begin
            cnt_reg   <= '0;
            state_reg <= (m_reg == 3'd0) ? S_DONE : S_WRITE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_WRITE: begin
          if (cnt_reg == {1'b0, m_reg} - 4'd1) begin
            cnt_reg   <= '0;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// Directed bench for tpu_core: table of matrix jobs with hand-computed results,
// plus restart-while-busy and reset-mid-write sequences.
module tb_tpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  m_in = '0;
  logic [3:0]  k_in = '0;
  logic [3:0]  n_in = '0;
  logic        done;
  logic [31:0] index_a, index_b, index_out;
  logic [31:0] data_out_a = '0;
  logic [31:0] data_out_b = '0;
  logic        wr_en_out;
  logic [31:0] data_in_o;

  tpu_core #(.ADDR_W(32), .WORD_W(32), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m_in), .k(k_in), .n(n_in),
    .done(done), .index_a(index_a), .data_out_a(data_out_a),
    .index_b(index_b), .data_out_b(data_out_b),
    .wr_en_out(wr_en_out), .index_out(index_out), .data_in_o(data_in_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        m;
    logic [3:0]        k;
    logic [3:0]        n;
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [3:0][31:0]  c;
    logic [7:0]        writes;
    logic [7:0]        lat;
  } job_t;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  job_t        vecs [8];
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] out_mem [4];
  int          wr_cnt;
  int          done_cnt;
  logic [31:0] max_idx;
  int          checks = 0;
  int          errors = 0;

  // Synchronous-read buffer models
  always @(posedge clk) begin
    data_out_a <= mem_a[index_a[3:0]];
    data_out_b <= mem_b[index_b[3:0]];
  end

  always @(negedge clk) begin
    if (wr_en_out) begin
      out_mem[index_out[1:0]] = data_in_o;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (index_a > max_idx) max_idx = index_a;
    if (index_b > max_idx) max_idx = index_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_job(input job_t v);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = v.a[i];
      mem_b[i] = v.b[i];
    end
    for (int i = 0; i < 4; i++) out_mem[i] = SENT;
    wr_cnt   = 0;
    done_cnt = 0;
    max_idx  = '0;
    m_in  = v.m;
    k_in  = v.k;
    n_in  = v.n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Dimension changes after latching must be ignored.
    m_in = 4'd1;
    k_in = 4'd9;
    n_in = 4'd2;
  endtask

  task automatic run_job(input int id, input job_t v, input int extra_start);
    int lat;
    logic [31:0] exp_max;
    lat = 0;
    start_job(v);
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk);
      #1;
      start = (j == extra_start);
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    exp_max = (v.k == 4'd0) ? 32'd0 : {28'd0, v.k - 4'd1};
    for (int r = 0; r < 4; r++) chk($sformatf("job%0d out[%0d]", id, r), out_mem[r], v.c[r]);
    chk($sformatf("job%0d writes", id), wr_cnt, {24'd0, v.writes});
    chk($sformatf("job%0d latency", id), lat, {24'd0, v.lat});
    chk($sformatf("job%0d max_index", id), max_idx, exp_max);
    chk($sformatf("job%0d done_pulses", id), done_cnt, 32'd1);
    $display("job %0d m=%0d k=%0d n=%0d lat=%0d writes=%0d out=%h %h %h %h",
             id, v.m, v.k, v.n, lat, wr_cnt, out_mem[0], out_mem[1], out_mem[2], out_mem[3]);
  endtask

  initial begin
    int got;
    for (int i = 0; i < 8; i++) vecs[i] = '0;

    // Identity A, B rows 1..16
    vecs[0].m = 4; vecs[0].k = 4; vecs[0].n = 4;
    for (int t = 0; t < 4; t++) vecs[0].a[t] = 32'h1 << (8 * t);
    vecs[0].b[0] = 32'h04030201; vecs[0].b[1] = 32'h08070605;
    vecs[0].b[2] = 32'h0C0B0A09; vecs[0].b[3] = 32'h100F0E0D;
    for (int r = 0; r < 4; r++) vecs[0].c[r] = vecs[0].b[r];
    vecs[0].writes = 4; vecs[0].lat = 16;

    // Masking: unused bytes carry 0x01 too
    vecs[1].m = 2; vecs[1].k = 3; vecs[1].n = 3;
    for (int t = 0; t < 3; t++) begin
      vecs[1].a[t] = 32'h01010101;
      vecs[1].b[t] = 32'h01010101;
    end
    vecs[1].c[0] = 32'h00030303; vecs[1].c[1] = 32'h00030303;
    vecs[1].c[2] = SENT; vecs[1].c[3] = SENT;
    vecs[1].writes = 2; vecs[1].lat = 13;

    // Positive saturation: 15 * 127 * 127
    vecs[2].m = 1; vecs[2].k = 15; vecs[2].n = 1;
    for (int t = 0; t < 15; t++) begin
      vecs[2].a[t] = 32'h0000007F;
      vecs[2].b[t] = 32'h0000007F;
    end
    vecs[2].c[0] = 32'h0000007F; vecs[2].c[1] = SENT; vecs[2].c[2] = SENT; vecs[2].c[3] = SENT;
    vecs[2].writes = 1; vecs[2].lat = 24;

    // Negative saturation: 15 * -128 * 127
    vecs[3] = vecs[2];
    for (int t = 0; t < 15; t++) vecs[3].a[t] = 32'h00000080;
    vecs[3].c[0] = 32'h00000080;

    // k = 0: all-zero result still written
    vecs[4].m = 4; vecs[4].k = 0; vecs[4].n = 4;
    vecs[4].a[0] = 32'h11223344; vecs[4].b[0] = 32'h55667788;
    vecs[4].writes = 4; vecs[4].lat = 12;

    // Mixed signs, m=3 with a junk byte in row 3 of A
    vecs[5].m = 3; vecs[5].k = 2; vecs[5].n = 4;
    vecs[5].a[0] = 32'h5503FF02; vecs[5].a[1] = 32'h00FE0401;
    vecs[5].b[0] = 32'h05FD0201; vecs[5].b[1] = 32'hFF040003;
    vecs[5].c[0] = 32'h09FE0405; vecs[5].c[1] = 32'hF713FE0B;
    vecs[5].c[2] = 32'h11EF06FD; vecs[5].c[3] = SENT;
    vecs[5].writes = 3; vecs[5].lat = 13;

    // m = 0: no writes
    vecs[6].m = 0; vecs[6].k = 2; vecs[6].n = 4;
    vecs[6].a[0] = 32'h01010101; vecs[6].b[0] = 32'h01010101;
    for (int r = 0; r < 4; r++) vecs[6].c[r] = SENT;
    vecs[6].writes = 0; vecs[6].lat = 10;

    // m, n above 4 clamp to 4
    vecs[7].m = 9; vecs[7].k = 1; vecs[7].n = 9;
    vecs[7].a[0] = 32'h04030201; vecs[7].b[0] = 32'h01010101;
    vecs[7].c[0] = 32'h01010101; vecs[7].c[1] = 32'h02020202;
    vecs[7].c[2] = 32'h03030303; vecs[7].c[3] = 32'h04040404;
    vecs[7].writes = 4; vecs[7].lat = 13;

    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    wr_cnt = 0; done_cnt = 0; max_idx = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst wr_en_out", {31'd0, wr_en_out}, 32'd0);
    chk("rst index_a", index_a, 32'd0);
    chk("rst index_out", index_out, 32'd0);
    chk("rst data_in_o", data_in_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(i, vecs[i], 0);

    // Second start mid-READ is ignored; same inputs give the same result
    run_job(8, vecs[0], 2);

    // Reset after 2 of 4 writes
    start_job(vecs[0]);
    got = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      #1;
      if (wr_cnt == 2) begin
        got = 1;
        break;
      end
    end
    chk("midrst reached 2 writes", got, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst wr_en_out", {31'd0, wr_en_out}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst index_out", index_out, 32'd0);
    chk("midrst data_in_o", data_in_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst no further writes", wr_cnt, 32'd2);
    chk("midrst no done", done_cnt, 32'd0);
    chk("midrst row2 untouched", out_mem[2], SENT);
    $display("midrst writes=%0d done_pulses=%0d", wr_cnt, done_cnt);

    run_job(9, vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
